br_cond_serial: RTL and testbench

- Multi-cycle, parametrised branch condition generator for the OTTER MCU.
- Compares two WIDTH-bit operands CHUNK bits per cycle, starting at the MSB chunk.
- Produces equal, signed-less-than and unsigned-less-than flags, plus a decoded branch-taken bit from the B-type funct3.
- Sits between the register file outputs and the PC-select logic of a multi-cycle datapath, with a START/DONE handshake to the control FSM.

---
 rtl/br_cond_serial.sv | 118 +++++++++++
 tb/tb_br_cond_serial.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/br_cond_serial.sv
// Multi-cycle branch condition generator: compares RS1/RS2 CHUNK bits per cycle, MSB chunk first.
// Optional macro BR_COND_EARLY_EXIT_EN ends the compare at the first differing chunk.
module br_cond_serial #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [2:0]       FUNCT3,
  input  logic [WIDTH-1:0] RS1,
  input  logic [WIDTH-1:0] RS2,
  output logic             BUSY,
  output logic             DONE,
  output logic             BR_EQ,
  output logic             BR_LT,
  output logic             BR_LTU,
  output logic             BR_TAKEN,
  output logic             ILLEGAL
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = $clog2(NCHUNK);

  typedef enum logic [1:0] {IDLE, CMP, FIN} state_t;

  state_t           state;
  logic [WIDTH-1:0] op1, op2;
  logic [2:0]       f3;
  logic [IW-1:0]    idx;
  logic             decided, ltu_acc;

  logic [CHUNK-1:0] chunk1, chunk2;
  logic             differ, first_diff, dec_next, ltu_next;
  logic             eq_next, lt_next, taken_next, finish;

  // Final flags are computed from the chunk being compared this cycle so
  // they can be registered on the same edge that enters FIN.
  always_comb begin
    chunk1     = op1[idx*CHUNK +: CHUNK];
    chunk2     = op2[idx*CHUNK +: CHUNK];
    differ     = (chunk1 != chunk2);
    first_diff = !decided && differ;
    dec_next   = decided || differ;
    ltu_next   = first_diff ? (chunk1 < chunk2) : ltu_acc;
    eq_next    = !dec_next;
    lt_next    = (op1[WIDTH-1] != op2[WIDTH-1]) ? op1[WIDTH-1] : ltu_next;
    case (f3)
      3'b000:  taken_next = eq_next;
      3'b001:  taken_next = !eq_next;
      3'b100:  taken_next = lt_next;
      3'b101:  taken_next = !lt_next;
      3'b110:  taken_next = ltu_next;
      3'b111:  taken_next = !ltu_next;
      default: taken_next = 1'b0;
    endcase
`ifdef BR_COND_EARLY_EXIT_EN
    finish = (idx == '0) || first_diff;
`else
    finish = (idx == '0);
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      op1      <= '0;
      op2      <= '0;
      f3       <= '0;
      idx      <= '0;
      decided  <= 1'b0;
      ltu_acc  <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      BR_EQ    <= 1'b0;
      BR_LT    <= 1'b0;
      BR_LTU   <= 1'b0;
      BR_TAKEN <= 1'b0;
      ILLEGAL  <= 1'b0;
    end else begin
      case (state)
        // FIN accepts a new request just like IDLE, allowing back-to-back use.
        IDLE, FIN: begin
          DONE <= 1'b0;
          if (START) begin
            op1     <= RS1;
            op2     <= RS2;
            f3      <= FUNCT3;
            idx     <= IW'(NCHUNK - 1);
            decided <= 1'b0;
            ltu_acc <= 1'b0;
            BUSY    <= 1'b1;
            state   <= CMP;
          end else begin
            state <= IDLE;
          end
        end
        CMP: begin
          decided <= dec_next;
          ltu_acc <= ltu_next;
          idx     <= idx - 1'b1;
          if (finish) begin
            state    <= FIN;
            BUSY     <= 1'b0;
            DONE     <= 1'b1;
            BR_EQ    <= eq_next;
            BR_LT    <= lt_next;
            BR_LTU   <= ltu_next;
            BR_TAKEN <= taken_next;
            ILLEGAL  <= (f3[2:1] == 2'b01);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_br_cond_serial.sv
// Directed self-checking bench for br_cond_serial (WIDTH=32, CHUNK=8).
module tb_br_cond_serial;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2;
  logic        busy, done, br_eq, br_lt, br_ltu, br_taken, illegal;

  int n_cmp = 0;
  int n_bad = 0;

  br_cond_serial #(.WIDTH(32), .CHUNK(8)) dut (
    .CLK(clk), .RST(rst), .START(start), .FUNCT3(funct3), .RS1(rs1), .RS2(rs2),
    .BUSY(busy), .DONE(done), .BR_EQ(br_eq), .BR_LT(br_lt), .BR_LTU(br_ltu),
    .BR_TAKEN(br_taken), .ILLEGAL(illegal)
  );

  always #5 clk = ~clk;

  // Pulses START for one cycle, then waits for DONE. Returns at the negedge of
  // the DONE cycle (cycle number relative to the START cycle) with BUSY count.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       output int done_cyc, output int busy_cnt);
    funct3 = f; rs1 = a; rs2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rs1 = ~a; rs2 = ~b; funct3 = ~f;
    done_cyc = -1; busy_cnt = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done) begin done_cyc = k; break; end
      if (busy) busy_cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; funct3 = '0; rs1 = '0; rs2 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy, done, br_eq, br_lt, br_ltu, br_taken, illegal} !== 7'b0) begin
      n_bad++;
      $display("[TB] FAIL reset_outputs got=%b want=0000000",
               {busy, done, br_eq, br_lt, br_ltu, br_taken, illegal});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_equal();
    int dc, bc;
    do_op(3'b000, 32'h12345678, 32'h12345678, dc, bc);
    n_cmp++;
    if (dc !== 5) begin n_bad++; $display("[TB] FAIL equal_done_cycle got=%0d want=5", dc); end
    n_cmp++;
    if (bc !== 4) begin n_bad++; $display("[TB] FAIL equal_busy_cycles got=%0d want=4", bc); end
    n_cmp++;
    if ({br_eq, br_lt, br_ltu, br_taken, illegal} !== 5'b10010) begin
      n_bad++;
      $display("[TB] FAIL equal_flags got=%b want=10010", {br_eq, br_lt, br_ltu, br_taken, illegal});
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if ({done, br_eq, br_taken} !== 3'b011) begin
      n_bad++;
      $display("[TB] FAIL equal_hold_after_fin got=%b want=011", {done, br_eq, br_taken});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_signed_lt();
    int dc, bc, exp_dc;
`ifdef BR_COND_EARLY_EXIT_EN
    exp_dc = 2;
`else
    exp_dc = 5;
`endif
    do_op(3'b100, 32'hFFFFFFFF, 32'h00000001, dc, bc);
    n_cmp++;
    if (dc !== exp_dc) begin n_bad++; $display("[TB] FAIL slt_done_cycle got=%0d want=%0d", dc, exp_dc); end
    n_cmp++;
    if ({br_eq, br_lt, br_ltu, br_taken, illegal} !== 5'b01010) begin
      n_bad++;
      $display("[TB] FAIL slt_flags got=%b want=01010", {br_eq, br_lt, br_ltu, br_taken, illegal});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned();
    int dc, bc, exp_dc;
`ifdef BR_COND_EARLY_EXIT_EN
    exp_dc = 4;
`else
    exp_dc = 5;
`endif
    do_op(3'b111, 32'h00000100, 32'h00000200, dc, bc);
    n_cmp++;
    if (dc !== exp_dc) begin n_bad++; $display("[TB] FAIL ltu_done_cycle got=%0d want=%0d", dc, exp_dc); end
    n_cmp++;
    if ({br_eq, br_lt, br_ltu, br_taken, illegal} !== 5'b01100) begin
      n_bad++;
      $display("[TB] FAIL ltu_flags got=%b want=01100", {br_eq, br_lt, br_ltu, br_taken, illegal});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_illegal();
    int dc, bc;
    do_op(3'b010, 32'd5, 32'd5, dc, bc);
    n_cmp++;
    if (dc !== 5) begin n_bad++; $display("[TB] FAIL illegal_done_cycle got=%0d want=5", dc); end
    n_cmp++;
    if ({br_eq, br_lt, br_ltu, br_taken, illegal} !== 5'b10001) begin
      n_bad++;
      $display("[TB] FAIL illegal_flags got=%b want=10001", {br_eq, br_lt, br_ltu, br_taken, illegal});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset();
    int dc, bc;
    bit saw_done;
    funct3 = 3'b001; rs1 = 32'hA; rs2 = 32'hB; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy, done, br_eq, br_lt, br_ltu, br_taken, illegal} !== 7'b0) begin
      n_bad++;
      $display("[TB] FAIL midreset_outputs got=%b want=0000000",
               {busy, done, br_eq, br_lt, br_ltu, br_taken, illegal});
    end
    saw_done = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    n_cmp++;
    if (saw_done !== 1'b0) begin n_bad++; $display("[TB] FAIL midreset_activity got=1 want=0"); end
    @(posedge clk); #1;
    do_op(3'b110, 32'h00000003, 32'h00000002, dc, bc);
    n_cmp++;
    if (dc !== 5) begin n_bad++; $display("[TB] FAIL post_reset_done_cycle got=%0d want=5", dc); end
    n_cmp++;
    if ({br_eq, br_lt, br_ltu, br_taken, illegal} !== 5'b00000) begin
      n_bad++;
      $display("[TB] FAIL post_reset_flags got=%b want=00000", {br_eq, br_lt, br_ltu, br_taken, illegal});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_start_ignored_busy();
    int dc;
    funct3 = 3'b110; rs1 = 32'h00000001; rs2 = 32'h00000002; start = 1'b1;
    @(posedge clk); #1;
    funct3 = 3'b000; rs1 = 32'h00000002; rs2 = 32'h00000001;
    dc = -1;
    for (int k = 1; k <= 20; k++) begin
      if (k == 4) start = 1'b0;
      @(negedge clk);
      if (done) begin dc = k; break; end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (dc !== 5) begin n_bad++; $display("[TB] FAIL ignore_done_cycle got=%0d want=5", dc); end
    n_cmp++;
    if ({br_eq, br_lt, br_ltu, br_taken, illegal} !== 5'b01110) begin
      n_bad++;
      $display("[TB] FAIL ignore_flags got=%b want=01110", {br_eq, br_lt, br_ltu, br_taken, illegal});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int dc, bc, exp_dc, exp_bc;
`ifdef BR_COND_EARLY_EXIT_EN
    exp_dc = 2; exp_bc = 1;
`else
    exp_dc = 5; exp_bc = 4;
`endif
    do_op(3'b000, 32'hCAFEF00D, 32'hCAFEF00D, dc, bc);
    n_cmp++;
    if (dc !== 5) begin n_bad++; $display("[TB] FAIL b2b_first_done got=%0d want=5", dc); end
    // Still at the negedge of the DONE cycle: issue the next request now.
    do_op(3'b001, 32'h80000000, 32'h7FFFFFFF, dc, bc);
    n_cmp++;
    if (dc !== exp_dc) begin n_bad++; $display("[TB] FAIL b2b_second_done got=%0d want=%0d", dc, exp_dc); end
    n_cmp++;
    if (bc !== exp_bc) begin n_bad++; $display("[TB] FAIL b2b_busy_cycles got=%0d want=%0d", bc, exp_bc); end
    n_cmp++;
    if ({br_eq, br_lt, br_ltu, br_taken, illegal} !== 5'b01010) begin
      n_bad++;
      $display("[TB] FAIL b2b_flags got=%b want=01010", {br_eq, br_lt, br_ltu, br_taken, illegal});
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_equal();
    test_signed_lt();
    test_unsigned();
    test_illegal();
    test_mid_reset();
    test_start_ignored_busy();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
